// File: rtl/filtered_dff_pkg.sv
// Shared definitions for the filtered D flip-flop bank: counter sizing helper and
// the per-channel action encoding used by each channel's next-state logic.
package filtered_dff_pkg;

    function automatic int cnt_width(input int stable);
        int w;
        w = $clog2(stable);
        return (w < 1) ? 1 : w;
    endfunction

    // What a channel does on an enabled edge, decided before any state is touched.
    typedef enum logic [1:0] {
        CH_HOLD    = 2'd0,
        CH_QUALIFY = 2'd1,
        CH_UPDATE  = 2'd2,
        CH_MATCH   = 2'd3
    } chan_act_e;

endpackage

// File: rtl/filtered_dff_chan.sv
// One debounced channel: qualification counter, q/qbar, rise/fall strobes and pending flag.
// FILTERED_DFF_SYNC2_EN adds a 2-flop input synchroniser ahead of the filter.
module filtered_dff_chan
    import filtered_dff_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o,
    output logic qbar_o,
    output logic rise_o,
    output logic fall_o,
    output logic pending_o
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic d_filt;

`ifdef FILTERED_DFF_SYNC2_EN
    logic [1:0] sync_q;

    // The synchroniser runs on every edge; en only gates the filter behind it.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign d_filt = sync_q[1];
`else
    assign d_filt = d_i;
`endif

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;
    logic          qbar_q, qbar_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          pend_q, pend_d;
    chan_act_e     act;

    always_comb begin
        act = CH_HOLD;
        if (en_i) begin
            if (d_filt == q_q) begin
                act = CH_MATCH;
            end else if (cnt_q == CNT_MAX) begin
                act = CH_UPDATE;
            end else begin
                act = CH_QUALIFY;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        qbar_d = qbar_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (act)
            CH_HOLD:    ;
            CH_MATCH:   cnt_d = '0;
            CH_QUALIFY: cnt_d = cnt_q + 1'b1;
            CH_UPDATE: begin
                cnt_d  = '0;
                q_d    = d_filt;
                qbar_d = ~d_filt;
                rise_d = d_filt;
                fall_d = ~d_filt;
            end
        endcase
        pend_d = (cnt_d != '0);
    end

    // NOTE: state registers use non-blocking assignments; qbar resets to 1 so it
    // stays the complement of q even while clear is held.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            cnt_q  <= '0;
            q_q    <= 1'b0;
            qbar_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            qbar_q <= qbar_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign q_o       = q_q;
    assign qbar_o    = qbar_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/filtered_dff_bank.sv
// Bank of WIDTH independently debounced flip-flops sharing clk, clear and en.
// Build option FILTERED_DFF_SYNC2_EN inserts a 2-flop synchroniser per channel.
module filtered_dff_bank #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pending
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        filtered_dff_chan #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk_i    (clk),
            .clear_i  (clear),
            .en_i     (en),
            .d_i      (d[i]),
            .q_o      (q[i]),
            .qbar_o   (qbar[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .pending_o(pending[i])
        );
    end

endmodule

// File: tb/tb_filtered_dff_bank.sv
// Self-checking bench: a 3-edge bank and a 1-edge bank on shared stimulus, checked
// every cycle against a streak-count model plus hand-computed directed expectations.
module tb_filtered_dff_bank;

    localparam int W = 4;
`ifdef FILTERED_DFF_SYNC2_EN
    localparam int LS = 2;
`else
    localparam int LS = 0;
`endif

    logic         clk   = 1'b0;
    logic         clear = 1'b0;
    logic         en    = 1'b1;
    logic [W-1:0] d     = '0;

    logic [W-1:0] qa, qbara, risea, falla, penda;
    logic [W-1:0] qb, qbarb, riseb, fallb, pendb;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    filtered_dff_bank #(.WIDTH(W), .STABLE_CYCLES(3)) u_dut_a (
        .clk(clk), .clear(clear), .en(en), .d(d),
        .q(qa), .qbar(qbara), .rise(risea), .fall(falla), .pending(penda)
    );

    filtered_dff_bank #(.WIDTH(W), .STABLE_CYCLES(1)) u_dut_b (
        .clk(clk), .clear(clear), .en(en), .d(d),
        .q(qb), .qbar(qbarb), .rise(riseb), .fall(fallb), .pending(pendb)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int thr(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    // Model: q changes once d has disagreed with it on thr consecutive enabled samples.
    logic [W-1:0] m_q    [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    int           m_run  [2][W];
    logic [W-1:0] m_s1, m_s2;

    always @(posedge clk or posedge clear) begin : model
        logic [W-1:0] smp;
        if (clear) begin
            m_s1 = '0;
            m_s2 = '0;
            for (int k = 0; k < 2; k++) begin
                m_q[k]    = '0;
                m_rise[k] = '0;
                m_fall[k] = '0;
                for (int c = 0; c < W; c++) m_run[k][c] = 0;
            end
        end else begin
            smp  = (LS != 0) ? m_s2 : d;
            m_s2 = m_s1;
            m_s1 = d;
            for (int k = 0; k < 2; k++) begin
                m_rise[k] = '0;
                m_fall[k] = '0;
                if (en) begin
                    for (int c = 0; c < W; c++) begin
                        if (smp[c] != m_q[k][c]) begin
                            m_run[k][c]++;
                            if (m_run[k][c] >= thr(k)) begin
                                m_q[k][c]    = smp[c];
                                m_rise[k][c] = smp[c];
                                m_fall[k][c] = ~smp[c];
                                m_run[k][c]  = 0;
                            end
                        end else begin
                            m_run[k][c] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] m_pend(input int k);
        logic [W-1:0] p;
        for (int c = 0; c < W; c++) p[c] = (m_run[k][c] != 0);
        return p;
    endfunction

    always @(negedge clk) begin
        check("cyc_q_a",    qa,    m_q[0]);
        check("cyc_qbar_a", qbara, ~m_q[0]);
        check("cyc_rise_a", risea, m_rise[0]);
        check("cyc_fall_a", falla, m_fall[0]);
        check("cyc_pend_a", penda, m_pend(0));
        check("cyc_q_b",    qb,    m_q[1]);
        check("cyc_qbar_b", qbarb, ~m_q[1]);
        check("cyc_rise_b", riseb, m_rise[1]);
        check("cyc_fall_b", fallb, m_fall[1]);
        check("cyc_pend_b", pendb, m_pend(1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 clear = 1'b1;
        wait_neg(2);
        check("rst_q",    qa,    4'h0);
        check("rst_qbar", qbara, 4'hF);
        check("rst_pend", penda, 4'h0);
        check("rst_qbarb", qbarb, 4'hF);
        clear = 1'b0;

        // Async clear mid-cycle with q=A.
        d = 4'hA;
        wait_neg(LS + 3);
        check("pre_clear_q", qa, 4'hA);
        @(posedge clk);
        #2 clear = 1'b1;
        #1;
        check("clr_async_q",    qa,    4'h0);
        check("clr_async_qbar", qbara, 4'hF);
        check("clr_async_rise", risea, 4'h0);
        check("clr_async_fall", falla, 4'h0);
        check("clr_async_qb",   qb,    4'h0);
        d = 4'h0;
        #10 clear = 1'b0;
        wait_neg(1);
        check("post_clear_q", qa, 4'h0);

        // Single channel rise then fall.
        d = 4'b0001;
        wait_neg(LS + 1);
        check("b_follow_q",    qb,    4'b0001);
        check("b_follow_rise", riseb, 4'b0001);
        check("a_wait_q",      qa,    4'h0);
        check("a_wait_pend",   penda, 4'b0001);
        wait_neg(1);
        check("a_wait2_q", qa, 4'h0);
        wait_neg(1);
        check("a_upd_q",    qa,    4'b0001);
        check("a_upd_rise", risea, 4'b0001);
        check("a_upd_qbar", qbara, 4'b1110);
        wait_neg(1);
        check("a_rise_once", risea, 4'h0);
        d = 4'h0;
        wait_neg(LS + 2);
        check("a_fall_wait_q", qa, 4'b0001);
        wait_neg(1);
        check("a_fall_q",    qa,    4'h0);
        check("a_fall_fall", falla, 4'b0001);

        // Two-edge pulse on d[1] is rejected.
        d = 4'b0010;
        wait_neg(2);
        d = 4'h0;
        wait_neg(LS);
        check("pulse_pend", penda, 4'b0010);
        wait_neg(1);
        check("pulse_q",    qa,    4'h0);
        check("pulse_pend0", penda, 4'h0);
        check("pulse_rise", risea, 4'h0);

        // Glitches strictly between edges are invisible.
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            repeat (18) #1 d = d ^ 4'h4;
        end
        wait_neg(LS + 1);
        check("glitch_q",    qa,    4'h0);
        check("glitch_pend", penda, 4'h0);
        check("glitch_qb",   qb,    4'h0);

        // en dropped after one qualifying edge.
        d = 4'hF;
        wait_neg(LS + 1);
        en = 1'b0;
        check("en_pend", penda, 4'hF);
        wait_neg(5);
        check("en_hold_q",    qa,    4'h0);
        check("en_hold_pend", penda, 4'hF);
        en = 1'b1;
        wait_neg(1);
        check("en_resume1_q", qa, 4'h0);
        wait_neg(1);
        check("en_resume2_q",    qa,    4'hF);
        check("en_resume2_rise", risea, 4'hF);
        wait_neg(1);
        check("en_rise_once", risea, 4'h0);

        // Staggered channels update on separate edges.
        d = 4'h0;
        wait_neg(LS + 3);
        check("stag_zero_q", qa, 4'h0);
        d = 4'b1000;
        wait_neg(1);
        d = 4'b1001;
        wait_neg(LS + 2);
        check("stag_q3",    qa,    4'b1000);
        check("stag_rise3", risea, 4'b1000);
        wait_neg(1);
        check("stag_q0",    qa,    4'b1001);
        check("stag_rise0", risea, 4'b0001);

        // Clear mid-qualification discards progress.
        d = 4'h0;
        wait_neg(LS + 3);
        d = 4'b1001;
        wait_neg(LS + 2);
        check("midclr_pend", penda, 4'b1001);
        check("midclr_q",    qa,    4'h0);
        clear = 1'b1;
        #2;
        check("midclr_pend0", penda, 4'h0);
        #1 clear = 1'b0;
        wait_neg(LS + 2);
        check("midclr_wait_q", qa, 4'h0);
        wait_neg(1);
        check("midclr_upd_q",    qa,    4'b1001);
        check("midclr_upd_rise", risea, 4'b1001);

        wait_neg(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
